// File: rtl/filter_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : filter_sched_pkg
// Description : Shared defaults and helpers for the filter input scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package filter_sched_pkg;

    localparam int PORTS_DEF         = 4;
    localparam int CHAN_PER_PORT_DEF = 32;
    localparam int CHANNELS_PW2_DEF  = 7;
    localparam int DEPTH_DEF         = 4;
    localparam int LOCAL_CHAN_W_DEF  = $clog2(CHAN_PER_PORT_DEF);
    localparam int SAMPLE_W          = 16;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_port_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sched_port_fifo
// Description : Per-port sample FIFO; a push into a full FIFO is accepted only
//               when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sched_port_fifo
    import filter_sched_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W + LOCAL_CHAN_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data
);

    localparam int AW = clog2_min1(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_accept;
    logic             w_do_pop;

    // Extra MSB distinguishes full from empty when the indices match.
    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop = pop && !empty;
    assign w_accept = push && (!full || w_do_pop);
    assign data     = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_input_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : filter_input_scheduler
// Description : Merges PORTS acquisition streams into one round-robin channel
//               stream. FILTER_INPUT_SCHEDULER_CHANNEL_MASK_EN adds chan_mask.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_input_scheduler
    import filter_sched_pkg::*;
#(
    parameter  int PORTS         = PORTS_DEF,
    parameter  int CHAN_PER_PORT = CHAN_PER_PORT_DEF,
    parameter  int CHANNELS_PW2  = CHANNELS_PW2_DEF,
    parameter  int DEPTH         = DEPTH_DEF,
    localparam int LOCAL_W       = $clog2(CHAN_PER_PORT)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [PORTS*SAMPLE_W-1:0]   port_sample,
    input  logic [PORTS*LOCAL_W-1:0]    port_chan,
    input  logic [PORTS-1:0]            port_valid,
`ifdef FILTER_INPUT_SCHEDULER_CHANNEL_MASK_EN
    input  logic [PORTS*CHAN_PER_PORT-1:0] chan_mask,
`endif
    output logic [SAMPLE_W-1:0]         chan_sample,
    output logic [CHANNELS_PW2-1:0]     chan_num,
    output logic                        chan_valid,
    input  logic                        chan_read,
    output logic [PORTS-1:0]            port_overflow,
    input  logic                        clear_overflow
);

    localparam int DW     = SAMPLE_W + LOCAL_W;
    localparam int PSEL_W = clog2_min1(PORTS);

    logic [PORTS-1:0]        w_push;
    logic [PORTS-1:0]        w_pop;
    logic [PORTS-1:0]        w_full;
    logic [PORTS-1:0]        w_empty;
    logic [PORTS-1:0]        w_drop;
    logic [DW-1:0]           w_fifo_data [PORTS];

    logic [PSEL_W-1:0]       w_sel;
    logic                    w_found;
    logic                    w_load;
    logic                    w_grant;
    logic [DW-1:0]           w_sel_data;
    int                      w_idx;

    logic                    r_valid;
    logic [SAMPLE_W-1:0]     r_sample;
    logic [CHANNELS_PW2-1:0] r_num;
    logic [PSEL_W-1:0]       r_last;
    logic [PORTS-1:0]        r_ovf;

    generate
        for (genvar p = 0; p < PORTS; p++) begin : g_port
`ifdef FILTER_INPUT_SCHEDULER_CHANNEL_MASK_EN
            logic [CHAN_PER_PORT-1:0] w_port_mask;
            assign w_port_mask = chan_mask[p*CHAN_PER_PORT +: CHAN_PER_PORT];
            // Masked channels vanish before the FIFO and never count as drops.
            assign w_push[p]   = port_valid[p] &
                                 w_port_mask[port_chan[p*LOCAL_W +: LOCAL_W]];
`else
            assign w_push[p]   = port_valid[p];
`endif
            assign w_drop[p]   = w_push[p] & w_full[p] & ~w_pop[p];

            sched_port_fifo #(
                .WIDTH (DW),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset_n   (reset_n),
                .push      (w_push[p]),
                .pop       (w_pop[p]),
                .push_data ({port_chan[p*LOCAL_W +: LOCAL_W],
                             port_sample[p*SAMPLE_W +: SAMPLE_W]}),
                .full      (w_full[p]),
                .empty     (w_empty[p]),
                .data      (w_fifo_data[p])
            );
        end
    endgenerate

    // Round-robin search starting just after the last granted port.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int off = 1; off <= PORTS; off++) begin
            w_idx = (int'(r_last) + off) % PORTS;
            if (!w_found && !w_empty[w_idx]) begin
                w_found = 1'b1;
                w_sel   = PSEL_W'(w_idx);
            end
        end
    end

    assign w_load     = !r_valid || chan_read;
    assign w_grant    = w_load && w_found;
    assign w_sel_data = w_fifo_data[w_sel];

    always_comb begin
        w_pop = '0;
        for (int p = 0; p < PORTS; p++) begin
            w_pop[p] = w_grant && (w_sel == PSEL_W'(p));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_sample <= '0;
            r_num    <= '0;
            r_last   <= PSEL_W'(PORTS - 1);
            r_ovf    <= '0;
        end else begin
            if (w_load) begin
                r_valid <= w_found;
            end
            if (w_grant) begin
                r_sample <= w_sel_data[SAMPLE_W-1:0];
                r_num    <= CHANNELS_PW2'({w_sel, w_sel_data[DW-1:SAMPLE_W]});
                r_last   <= w_sel;
            end
            // A drop on the clearing edge wins over the clear.
            r_ovf <= (r_ovf & ~{PORTS{clear_overflow}}) | w_drop;
        end
    end

    assign chan_valid    = r_valid;
    assign chan_sample   = r_sample;
    assign chan_num      = r_num;
    assign port_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_filter_input_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_filter_input_scheduler
// Description : Directed self-checking bench for filter_input_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_input_scheduler;

    localparam int PORTS = 4;
    localparam int LW    = 5;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [63:0]     port_sample = '0;
    logic [19:0]     port_chan = '0;
    logic [3:0]      port_valid = '0;
`ifdef FILTER_INPUT_SCHEDULER_CHANNEL_MASK_EN
    logic [127:0]    chan_mask = '1;
`endif
    logic [15:0]     chan_sample;
    logic [6:0]      chan_num;
    logic            chan_valid;
    logic            chan_read = 1'b1;
    logic [3:0]      port_overflow;
    logic            clear_overflow = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    filter_input_scheduler u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .port_sample    (port_sample),
        .port_chan      (port_chan),
        .port_valid     (port_valid),
`ifdef FILTER_INPUT_SCHEDULER_CHANNEL_MASK_EN
        .chan_mask      (chan_mask),
`endif
        .chan_sample    (chan_sample),
        .chan_num       (chan_num),
        .chan_valid     (chan_valid),
        .chan_read      (chan_read),
        .port_overflow  (port_overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_port(input int p, input int ch, input logic [15:0] smp);
        port_sample[p*16 +: 16] = smp;
        port_chan[p*LW +: LW]   = LW'(ch);
        port_valid[p]           = 1'b1;
    endtask

    task automatic expect_out(input string tag, input logic v, input int num, input logic [15:0] smp);
        check({tag, "_valid"}, 32'(chan_valid), 32'(v));
        if (v) begin
            check({tag, "_num"}, 32'(chan_num), 32'(num));
            check({tag, "_sample"}, 32'(chan_sample), 32'(smp));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int seen;
        logic       rd_pat  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] exp_idx [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

        // Reset state
        tick();
        check("rst_valid", 32'(chan_valid), 32'd0);
        check("rst_sample", 32'(chan_sample), 32'd0);
        check("rst_num", 32'(chan_num), 32'd0);
        check("rst_ovf", 32'(port_overflow), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single push: port 2 chan 5 -> global 69, two-edge latency
        chan_read = 1'b1;
        push_port(2, 5, 16'h8123);
        tick();
        port_valid = '0;
        expect_out("single_e1", 1'b0, 0, 16'h0);
        tick();
        expect_out("single_e2", 1'b1, 69, 16'h8123);
        tick();
        expect_out("single_e3", 1'b0, 0, 16'h0);

        // Simultaneous bursts from all ports come out in port order 0..3
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < PORTS; p++) push_port(p, 3, 16'h1000 + 16'(b*16 + p));
            tick();
            port_valid = '0;
            expect_out("burst_push", 1'b0, 0, 16'h0);
            for (int k = 0; k < PORTS; k++) begin
                tick();
                expect_out($sformatf("burst%0d_p%0d", b, k), 1'b1, k*32 + 3, 16'h1000 + 16'(b*16 + k));
            end
            tick();
            expect_out("burst_end", 1'b0, 0, 16'h0);
        end

        // Stalled output: 1 in output + 4 buffered, 6th dropped; set beats clear
        chan_read = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_port(1, 2, 16'hA001 + 16'(i));
            if (i == 5) clear_overflow = 1'b1;
            tick();
            if (i == 4) check("ovf_before_drop", 32'(port_overflow), 32'h0);
        end
        port_valid = '0;
        clear_overflow = 1'b0;
        check("ovf_set_wins", 32'(port_overflow), 32'h2);
        expect_out("stall_out", 1'b1, 34, 16'hA001);
        repeat (128) tick();
        expect_out("stall_long", 1'b1, 34, 16'hA001);
        check("ovf_sticky", 32'(port_overflow), 32'h2);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("ovf_cleared", 32'(port_overflow), 32'h0);
        chan_read = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            expect_out($sformatf("drain%0d", k), 1'b1, 34, 16'hA001 + 16'(k));
        end
        tick();
        expect_out("drain_end", 1'b0, 0, 16'h0);

        // chan_read toggling: data stable when stalled, each sample once
        chan_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_port(0, 7, 16'hB001 + 16'(i));
            tick();
        end
        port_valid = '0;
        for (int i = 0; i < 6; i++) begin
            chan_read = rd_pat[i];
            tick();
            expect_out($sformatf("toggle%0d", i), exp_idx[i] != 2'd3, 7, 16'hB001 + 16'(exp_idx[i]));
        end

        // Mid-operation reset discards everything
        chan_read = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 3; p++) push_port(p, i, 16'hE000 + 16'(p*2 + i));
            tick();
        end
        port_valid = '0;
        check("pre_reset_valid", 32'(chan_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(chan_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        chan_read = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (chan_valid) seen++;
        end
        check("post_reset_silent", 32'(seen), 32'd0);
        push_port(3, 1, 16'hC333);
        tick();
        port_valid = '0;
        expect_out("post_reset_e1", 1'b0, 0, 16'h0);
        tick();
        expect_out("post_reset_e2", 1'b1, 97, 16'hC333);
        tick();

`ifdef FILTER_INPUT_SCHEDULER_CHANNEL_MASK_EN
        // Masked global channel 33 is silently dropped
        chan_mask[33] = 1'b0;
        push_port(1, 1, 16'hD001);
        tick();
        port_valid = '0;
        tick();
        tick();
        expect_out("mask_drop", 1'b0, 0, 16'h0);
        check("mask_no_ovf", 32'(port_overflow), 32'h0);
        push_port(1, 2, 16'hD002);
        tick();
        port_valid = '0;
        tick();
        expect_out("mask_pass", 1'b1, 34, 16'hD002);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter_input_scheduler.md
FILTER_INPUT_SCHEDULER -- requirements
Module: filter_input_scheduler

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of independent acquisition ports merged.
REQ-002 SHALL have parameter CHAN_PER_PORT, default 32, channels per port; power of two.
REQ-003 SHALL have parameter CHANNELS_PW2, default 7, log2(PORTS*CHAN_PER_PORT).
REQ-004 SHALL have parameter DEPTH, default 4, per-port FIFO entries; power of two, >=2.
REQ-005 SHALL have ports: clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: port_sample  in  PORTS*16  offset-binary samples, port p at [16p+15:16p]; port_chan  in  PORTS*log2(CHAN_PER_PORT)  local channel index; port_valid  in  PORTS  one-cycle push strobe per port.
REQ-007 SHALL have ports: chan_sample  out  16  merged sample; chan_num  out  CHANNELS_PW2  global channel; chan_valid  out  1  output holds data; chan_read  in  1  downstream filter ready.
REQ-008 SHALL have ports: port_overflow  out  PORTS  sticky drop flag; clear_overflow  in  1  one-cycle clear pulse.

Function
REQ-009 SHALL push port p sample into port p FIFO on every clk edge where port_valid[p]=1; ports have no backpressure.
REQ-010 SHALL, when FIFO p is full and port_valid[p]=1, discard the new sample, keep FIFO contents, set port_overflow[p].
REQ-011 SHALL treat push to a full FIFO coinciding with a pop of that FIFO as accepted (no drop).
REQ-012 SHALL transfer output only on edges with chan_valid=1 and chan_read=1; chan_sample/chan_num stable while chan_valid=1 and chan_read=0.
REQ-013 SHALL load output register when empty or being transferred in the same cycle, from the granted non-empty FIFO (pop on same edge).
REQ-014 SHALL grant round-robin: search starts at port (last_grant+1) mod PORTS; last_grant updates only on a grant.
REQ-015 SHALL form chan_num = p*CHAN_PER_PORT + port_chan (concatenation {p, local}); chan_sample passed unmodified.
REQ-016 SHALL deliver a sample pushed into an empty idle system on chan_valid two cycles after the push cycle (push edge, load edge).
REQ-017 SHALL sustain one transfer per cycle when chan_read stays 1 and any FIFO is non-empty.
REQ-018 SHALL preserve per-port order; no sample duplicated or lost except per REQ-010.
REQ-019 SHALL tolerate chan_read held low for any duration (filter flush after its reset: CHANNELS cycles), buffering up to DEPTH per port plus the output register.
REQ-020 SHALL clear port_overflow on clear_overflow=1; simultaneous set and clear on same port -> flag set.
REQ-021 SHALL wrap FIFO pointers modulo DEPTH; full/empty distinguished by one extra pointer bit.

Reset
REQ-022 SHALL, on reset_n=0 asynchronously: chan_valid=0, chan_sample=0, chan_num=0, FIFOs empty, last_grant=PORTS-1 (first grant to port 0), port_overflow=0.
REQ-023 SHALL discard all buffered and in-flight samples when reset asserts mid-operation; first push after release behaves per REQ-016.

Configuration
REQ-024 SHALL support macro FILTER_INPUT_SCHEDULER_CHANNEL_MASK_EN; when defined, adds input chan_mask (PORTS*CHAN_PER_PORT bits, bit = global channel) and drops pushes for channels with mask bit 0 before the FIFO, without setting port_overflow.
REQ-025 SHALL, when the macro is undefined, have no chan_mask port and forward every channel.

Structure
REQ-026 SHALL place PORTS, CHAN_PER_PORT, CHANNELS_PW2, DEPTH defaults and derived local-channel width in shared package filter_sched_pkg.
REQ-027 SHALL implement each per-port buffer as one sub-module, sched_port_fifo (push, pop, full, empty, data), instantiated PORTS times.

Verification
REQ-028 Single push port 2 chan 5 sample 0x8123, chan_read=1 -> chan_valid two cycles later, chan_num=69, chan_sample=0x8123, one cycle.
REQ-029 All 4 ports push simultaneously, chan_read=1 -> outputs in port order 0,1,2,3 on consecutive cycles; repeated bursts keep rotation.
REQ-030 chan_read=0 for 128 cycles, port 1 pushes 6 samples -> 4 buffered plus 1 in output, 6th dropped, port_overflow=4'b0010; clear_overflow clears it.
REQ-031 Output stalled with chan_valid=1, chan_read toggling 0/1 -> data stable while stalled, each sample delivered exactly once.
REQ-032 reset_n pulsed low with 3 FIFOs non-empty -> chan_valid=0 immediately, nothing emitted after release until new push.
REQ-033 Macro defined, chan_mask bit 33 clear, port 1 chan 1 pushed -> no output, port_overflow unchanged; other channels pass.
